// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and default sizes for the register-file arbiter.
// Optional feature macro: REG_FILE_ARBITER_BYPASS_EN (see reg_file_arbiter.sv).
package reg_file_arbiter_pkg;

   localparam int unsigned WORD_SIZE_DEF      = 32;
   localparam int unsigned REG_FILE_SIZE_DEF  = 5;
   localparam int unsigned REG_STACK_SIZE_DEF = 32;
   localparam int unsigned STARVE_LIMIT_DEF   = 3;

   typedef enum logic [1:0] {
      StInit,
      StClearWait,
      StRun
   } arb_state_e;

endpackage

// File: rtl/reg_file_arbiter_if.sv
// Requester-side bundle: decode-stage read port and writeback-stage write port.
// master = requesters, slave = arbiter.
interface reg_file_arbiter_if
   import reg_file_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE     = WORD_SIZE_DEF,
   parameter int unsigned REG_FILE_SIZE = REG_FILE_SIZE_DEF
) ();

   logic                     rd_req;
   logic [REG_FILE_SIZE-1:0] rd_num1;
   logic [REG_FILE_SIZE-1:0] rd_num2;
   logic [REG_FILE_SIZE-1:0] rd_num3;
   logic                     rd_gnt;
   logic                     rd_valid;
   logic [WORD_SIZE-1:0]     rd_val1;
   logic [WORD_SIZE-1:0]     rd_val2;
   logic [WORD_SIZE-1:0]     rd_val3;

   logic                     wr_req;
   logic [REG_FILE_SIZE-1:0] wr_num;
   logic [WORD_SIZE-1:0]     wr_val;
   logic                     wr_gnt;

   modport master (
      output rd_req, rd_num1, rd_num2, rd_num3, wr_req, wr_num, wr_val,
      input  rd_gnt, rd_valid, rd_val1, rd_val2, rd_val3, wr_gnt
   );

   modport slave (
      input  rd_req, rd_num1, rd_num2, rd_num3, wr_req, wr_num, wr_val,
      output rd_gnt, rd_valid, rd_val1, rd_val2, rd_val3, wr_gnt
   );

endinterface

// File: rtl/reg_arb_starve_ctr.sv
// Saturating count of consecutive cycles a pending read lost to a write;
// force_read_o is high once the count reaches STARVE_LIMIT.
module reg_arb_starve_ctr
   import reg_file_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic clr_i,
   output logic force_read_o
);

   localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != Limit)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_read_o = (cnt_q == Limit);

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares a one-action-per-cycle register file between a 3-operand reader and a writer.
// Define REG_FILE_ARBITER_BYPASS_EN to let forced reads win on hazards and forward wr_val.
module reg_file_arbiter
   import reg_file_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE      = WORD_SIZE_DEF,
   parameter int unsigned REG_FILE_SIZE  = REG_FILE_SIZE_DEF,
   parameter int unsigned REG_STACK_SIZE = REG_STACK_SIZE_DEF,
   parameter int unsigned STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   reg_file_arbiter_if.slave        req_if,
   output logic [REG_FILE_SIZE-1:0] rf_get_num1_o,
   output logic [REG_FILE_SIZE-1:0] rf_get_num2_o,
   output logic [REG_FILE_SIZE-1:0] rf_get_num3_o,
   output logic [REG_FILE_SIZE-1:0] rf_set_num_o,
   output logic [WORD_SIZE-1:0]     rf_set_val_o,
   output logic                     rf_get_enable_o,
   output logic                     rf_set_enable_o,
   output logic                     rf_reset_enable_o,
   input  logic [WORD_SIZE-1:0]     rf_out1_i,
   input  logic [WORD_SIZE-1:0]     rf_out2_i,
   input  logic [WORD_SIZE-1:0]     rf_out3_i
);

   arb_state_e state_q, state_d;

   logic rd_gnt, wr_gnt, init_clear;
   logic force_read, forced_read_ok;
   logic starve_inc, starve_clr;
   logic [2:0] hit;

   logic [REG_FILE_SIZE-1:0] get_num1_q, get_num2_q, get_num3_q, set_num_q;
   logic [WORD_SIZE-1:0]     set_val_q;
   logic                     rd_valid_q;

   logic [2:0][WORD_SIZE-1:0] rf_out, rd_src, rd_val_q, rd_val;

   assign hit = {req_if.wr_num == req_if.rd_num3,
                 req_if.wr_num == req_if.rd_num2,
                 req_if.wr_num == req_if.rd_num1};

`ifdef REG_FILE_ARBITER_BYPASS_EN
   assign forced_read_ok = force_read;
`else
   assign forced_read_ok = force_read && !(|hit);
`endif

   always_comb begin
      state_d    = state_q;
      init_clear = 1'b0;
      rd_gnt     = 1'b0;
      wr_gnt     = 1'b0;
      unique case (state_q)
         StInit: begin
            init_clear = 1'b1;
            state_d    = StClearWait;
         end
         StClearWait: begin
            state_d = StRun;
         end
         StRun: begin
            if (req_if.rd_req && (!req_if.wr_req || forced_read_ok)) begin
               rd_gnt = 1'b1;
            end else if (req_if.wr_req) begin
               wr_gnt = 1'b1;
            end
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   assign starve_inc = wr_gnt & req_if.rd_req;
   assign starve_clr = rd_gnt | ~req_if.rd_req;

   reg_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk_i        (clk),
      .rst_ni       (reset_n),
      .inc_i        (starve_inc),
      .clr_i        (starve_clr),
      .force_read_o (force_read)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StInit;
         rd_valid_q <= 1'b0;
         get_num1_q <= '0;
         get_num2_q <= '0;
         get_num3_q <= '0;
         set_num_q  <= '0;
         set_val_q  <= '0;
         rd_val_q   <= '0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_gnt;
         if (rd_gnt) begin
            get_num1_q <= req_if.rd_num1;
            get_num2_q <= req_if.rd_num2;
            get_num3_q <= req_if.rd_num3;
         end
         if (wr_gnt) begin
            set_num_q <= req_if.wr_num;
            set_val_q <= req_if.wr_val;
         end
         if (rd_valid_q) begin
            rd_val_q <= rd_src;
         end
      end
   end

   assign rf_out = {rf_out3_i, rf_out2_i, rf_out1_i};

`ifdef REG_FILE_ARBITER_BYPASS_EN
   // Operands that matched a pending write at grant time take the captured wr_val.
   logic [2:0]           byp_hit_q;
   logic [WORD_SIZE-1:0] byp_val_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byp_hit_q <= '0;
         byp_val_q <= '0;
      end else if (rd_gnt) begin
         byp_hit_q <= hit & {3{req_if.wr_req}};
         byp_val_q <= req_if.wr_val;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rd_src[i] = byp_hit_q[i] ? byp_val_q : rf_out[i];
      end
   end
`else
   assign rd_src = rf_out;
`endif

   assign rd_val = rd_valid_q ? rd_src : rd_val_q;

   assign req_if.rd_gnt   = rd_gnt;
   assign req_if.wr_gnt   = wr_gnt;
   assign req_if.rd_valid = rd_valid_q;
   assign req_if.rd_val1  = rd_val[0];
   assign req_if.rd_val2  = rd_val[1];
   assign req_if.rd_val3  = rd_val[2];

   // Address/data lines hold their last granted value when idle.
   assign rf_get_num1_o = rd_gnt ? req_if.rd_num1 : get_num1_q;
   assign rf_get_num2_o = rd_gnt ? req_if.rd_num2 : get_num2_q;
   assign rf_get_num3_o = rd_gnt ? req_if.rd_num3 : get_num3_q;
   assign rf_set_num_o  = wr_gnt ? req_if.wr_num : set_num_q;
   assign rf_set_val_o  = wr_gnt ? req_if.wr_val : set_val_q;

   assign rf_get_enable_o   = rd_gnt;
   assign rf_set_enable_o   = wr_gnt;
   // State resets to StInit, so gate the clear strobe to keep it low while in reset.
   assign rf_reset_enable_o = init_clear & reset_n;

`ifndef SYNTHESIS
   a_wr_addr_in_range: assert property (@(posedge clk) disable iff (!reset_n)
      wr_gnt |-> (32'(req_if.wr_num) < REG_STACK_SIZE));
`endif

endmodule
